demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//   Round-robin dispatch controller for the 1:4 demultiplexer datapath.
//   Accepts a single valid/ready input stream and delivers bursts of up to
//   BURST_LEN items to one of four output channels at a time.
//   Drives the demux select, and holds one item in a registered output stage.
//   Sits between a single producer and four consumers that share the demux.
// PARAMETERS
//   DW         8   data width of each item
//   BURST_LEN  4   max items sent to one channel before rotating (1..255)
//   GAP_MAX    2   consecutive idle input cycles that end a burst early (1..15)
// PORTS
//   clk        in   1    single clock, all logic on posedge
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    producer has an item on in_data
//   in_data    in   DW   input item
//   in_ready   out  1    controller accepts in_data this cycle
//   out_ready  in   4    per-channel consumer ready, bit k = channel k
//   out_valid  out  4    one-hot, bit sel set while the held item is valid
//   out_data   out  DW   held item, common to all channels
//   sel        out  2    current demux select (channel being served)
//   busy       out  1    high in STREAM state
//   xfer_cnt   out  16   total items delivered, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset values (rst high at a clk edge, wins over everything):
//   - state=SEEK, ptr=0, sel=0, cnt=0, gap=0, hold empty, out_valid=0,
//     out_data=0, xfer_cnt=0.
//   - in_ready is combinational and is 0 during reset.
//   - Any held item is dropped, including one in the middle of a burst.
//   Delivery:
//   - deliver = out_valid[sel] & out_ready[sel]; xfer_cnt += 1 on deliver.
//   Acceptance:
//   - accept = in_valid & in_ready.
//   - in_ready = (state==STREAM) & (cnt!=BURST_LEN) & (!hold | out_ready[sel]).
//   - Accept and deliver may occur in the same cycle (pass-through, no bubble).
//   - An item accepted at edge N is on out_data/out_valid after edge N
//     (latency 1).
//   - out_data is stable while held and not delivered.
//   SEEK state:
//   - Scans out_ready in order ptr, ptr+1, ... (mod 4).
//   - The first ready channel c gives sel<=c, cnt<=0, gap<=0, state<=STREAM.
//   - If no channel is ready, the block stays in SEEK and ptr is unchanged.
//   - One cycle minimum in SEEK; in_ready=0 throughout.
//   STREAM state:
//   - cnt increments on accept.
//   - gap increments on cycles with !in_valid and no hold; it clears on in_valid.
//   - The burst ends when (cnt==BURST_LEN | gap==GAP_MAX) and the hold is
//     empty or delivering this cycle. Then ptr<=sel+1 (wraps 3->0) and
//     state<=SEEK.
//   - If out_ready[sel] drops mid-burst, the item stalls in hold. There is no
//     re-arbitration and no timeout; the block waits for the consumer.
//   - sel changes only on the SEEK->STREAM transition.
// TESTING
//   1 Reset: after rst, out_valid=0, sel=0, xfer_cnt=0, in_ready=0 in the
//     first cycle.
//   2 Rotation: out_ready=4'b1111, in_valid held high, data 1..16 ->
//     ch0 gets 1-4, ch1 5-8, ch2 9-12, ch3 13-16. One SEEK bubble between
//     bursts; xfer_cnt=16.
//   3 Skip: out_ready=4'b0100 from reset -> sel=2, all items go to ch2.
//     After a burst, SEEK returns to ch2 (ptr=3 wraps around).
//   4 Backpressure: drop out_ready[sel] after item 2 for 5 cycles.
//     Required: item 3 held stable, in_ready=0; it is delivered on the first
//     cycle ready returns, with no loss or duplication.
//   5 Early end: send 1 item to ch0, then in_valid=0 for GAP_MAX cycles ->
//     state returns to SEEK and the next item goes to ch1.
//   6 Mid-burst reset: assert rst with the hold full -> item dropped,
//     out_valid=0, xfer_cnt=0, next burst starts at ch0.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: round-robin burst dispatcher driving a 1:4 demux with a one-item registered output stage
module demux_dispatch_ctrl #(
  parameter int DW = 8,
  parameter int BURST_LEN = 4,
  parameter int GAP_MAX = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    out_ready,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [15:0]   xfer_cnt
);
  localparam logic [0:0] SEEK = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
  localparam logic [3:0] GAP_LIM = 4'(GAP_MAX);
  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, off;
  logic [7:0] cnt_q, cnt_d, rot;
  logic [3:0] gap_q, gap_d;
  logic hold_q, hold_d, deliver, accept, burst_end, seek_hit;
  logic [DW-1:0] data_q, data_d;
  logic [15:0] xfer_q, xfer_d;
  // rot[i] is the ready bit of channel ptr+i, so the first set bit is the scan winner
  assign rot = {out_ready, out_ready} >> ptr_q;
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign seek_hit = (state_q == SEEK) & (|out_ready);
  assign deliver = hold_q & out_ready[sel_q];
  assign in_ready = !rst & (state_q == STREAM) & (cnt_q != BURST_MAX) & (!hold_q | out_ready[sel_q]);
  assign accept = in_valid & in_ready;
  // an item arriving on the idle-limit cycle keeps the burst alive so the hold never changes channel
  assign burst_end = (state_q == STREAM) & ((cnt_q == BURST_MAX) | (gap_q == GAP_LIM)) & (!hold_q | deliver) & !accept;
  always_comb begin
    state_d = seek_hit ? STREAM : burst_end ? SEEK : state_q;
    ptr_d = burst_end ? sel_q + 2'd1 : ptr_q;
    sel_d = seek_hit ? ptr_q + off : sel_q;
    cnt_d = (state_q == SEEK) ? 8'd0 : cnt_q + 8'(accept);
    gap_d = ((state_q == SEEK) | in_valid) ? 4'd0 : hold_q ? gap_q : gap_q + 4'd1;
    hold_d = accept | (hold_q & !deliver);
    data_d = accept ? in_data : data_q;
    xfer_d = xfer_q + 16'(deliver);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEEK;
      ptr_q <= 2'd0;
      sel_q <= 2'd0;
      cnt_q <= 8'd0;
      gap_q <= 4'd0;
      hold_q <= 1'b0;
      data_q <= '0;
      xfer_q <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      hold_q <= hold_d;
      data_q <= data_d;
      xfer_q <= xfer_d;
    end
  end
  assign out_valid = 4'(hold_q) << sel_q;
  assign out_data = data_q;
  assign sel = sel_q;
  assign busy = (state_q == STREAM);
  assign xfer_cnt = xfer_q;
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: scoreboard bench with a transaction-level reference model of the dispatcher
module tb_demux_dispatch_ctrl;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int GM = 2;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, busy;
  logic [DW-1:0] in_data = 0, out_data;
  logic [3:0] out_ready = 0, out_valid;
  logic [1:0] sel;
  logic [15:0] xfer_cnt;
  typedef struct {logic [1:0] ch; logic [7:0] d;} item_t;
  item_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  bit m_stream, m_held, m_acc, a_acc, a_dlv, a_fin, a_found;
  int m_ptr, m_sel, m_cnt, m_gap;
  logic [7:0] m_data;
  logic [15:0] m_xfer;
  int del_ch[256];

  demux_dispatch_ctrl #(.DW(DW), .BURST_LEN(BL), .GAP_MAX(GM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .sel(sel),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_in_ready();
    return !rst && m_stream && m_cnt != BL && (!m_held || out_ready[m_sel]);
  endfunction

  // reference model: channel scan, burst/idle accounting and the single hold slot
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_stream = 0; m_ptr = 0; m_sel = 0; m_cnt = 0; m_gap = 0;
      m_held = 0; m_data = 0; m_xfer = 0; m_acc = 0;
      exp_q.delete();
    end else begin
      a_acc = in_valid && exp_in_ready();
      a_dlv = m_held && out_ready[m_sel];
      if (!m_stream) begin
        a_found = 0;
        for (int i = 0; i < 4; i++)
          if (!a_found && out_ready[(m_ptr + i) % 4]) begin
            a_found = 1;
            m_sel = (m_ptr + i) % 4;
          end
        if (a_found) begin m_stream = 1; m_cnt = 0; m_gap = 0; end
      end else begin
        a_fin = (m_cnt == BL || m_gap == GM) && (!m_held || a_dlv) && !a_acc;
        m_cnt = m_cnt + int'(a_acc);
        m_gap = in_valid ? 0 : (m_held ? m_gap : m_gap + 1);
        if (a_fin) begin m_ptr = (m_sel + 1) % 4; m_stream = 0; end
      end
      if (a_acc) begin
        exp_q.push_back('{ch: 2'(m_sel), d: in_data});
        m_data = in_data;
      end
      if (a_dlv) m_xfer = m_xfer + 16'd1;
      m_held = a_acc || (m_held && !a_dlv);
      m_acc = a_acc;
    end
  end

  // monitor: compares every cycle and pops the scoreboard whenever the DUT delivers
  initial forever begin
    item_t it;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
    chk("out_valid", 32'(out_valid), m_held ? 32'(4'b1 << m_sel) : 32'd0);
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_stream));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
    if (|(out_valid & out_ready)) begin
      if (exp_q.size() == 0) chk("unexpected_delivery", 32'(out_data), 32'hFFFF_FFFF);
      else begin
        it = exp_q.pop_front();
        chk("deliver_ch", 32'(out_valid & out_ready), 32'(4'b1 << it.ch));
        chk("deliver_data", 32'(out_data), 32'(it.d));
        del_ch[it.d] = it.ch;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step();
    tick();
    if (m_acc) in_data = in_data + 8'd1;
  endtask

  task automatic send_n(input int n);
    int got = 0, t = 0;
    in_valid = 1;
    while (got < n && t < 500) begin
      tick();
      t++;
      if (m_acc) begin got++; in_data = in_data + 8'd1; end
    end
    in_valid = 0;
    if (got < n) chk("send_timeout", 32'(got), 32'(n));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 256; i++) del_ch[i] = -1;
    in_valid = 0;
    rst = 1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 0;
    chk("rst1_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // rotation across all four channels
    do_reset();
    out_ready = 4'b1111;
    in_data = 1;
    send_n(16);
    repeat (6) tick();
    chk("rot_xfer", 32'(xfer_cnt), 32'd16);
    for (int d = 1; d <= 16; d++) chk("rot_ch", 32'(del_ch[d]), 32'((d - 1) / 4));
    // only channel 2 ready: every burst returns to it
    do_reset();
    out_ready = 4'b0100;
    in_data = 1;
    send_n(10);
    repeat (6) tick();
    for (int d = 1; d <= 10; d++) chk("skip_ch", 32'(del_ch[d]), 32'd2);
    // backpressure on the served channel after two deliveries
    do_reset();
    out_ready = 4'b1111;
    in_data = 1;
    in_valid = 1;
    t = 0;
    while (m_xfer != 16'd2 && t < 100) begin step(); t++; end
    chk("bp_reach2", 32'(m_xfer), 32'd2);
    out_ready = 4'b1110;
    repeat (5) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'd3);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 4'b1111;
    repeat (10) step();
    in_valid = 0;
    repeat (8) tick();
    chk("bp_item3_ch", 32'(del_ch[3]), 32'd0);
    // idle gap ends the burst early
    do_reset();
    out_ready = 4'b1111;
    in_data = 1;
    send_n(1);
    repeat (GM + 4) tick();
    send_n(1);
    repeat (4) tick();
    chk("gap_first_ch", 32'(del_ch[1]), 32'd0);
    chk("gap_next_ch", 32'(del_ch[2]), 32'd1);
    // reset with a stalled item in the hold
    do_reset();
    out_ready = 4'b0001;
    in_data = 8'h40;
    send_n(1);
    out_ready = 4'b0000;
    repeat (2) tick();
    chk("mrst_held", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 4'b1111;
    in_data = 8'h50;
    send_n(1);
    repeat (3) tick();
    chk("mrst_next_ch", 32'(del_ch[8'h50]), 32'd0);
    chk("mrst_dropped", 32'(del_ch[8'h40]), 32'hFFFF_FFFF);
    // randomized traffic against the model
    do_reset();
    repeat (3000) begin
      in_valid = ($urandom % 4) != 0;
      in_data = 8'($urandom);
      out_ready = ($urandom % 8 == 0) ? 4'b0000 : 4'($urandom);
      tick();
    end
    in_valid = 0;
    out_ready = 4'b1111;
    repeat (20) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
